// File: rtl/fog_param_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : fog_param_scheduler_if
// Description : Bundle of the register-bank side and FOG-core side signals
//               of fog_param_scheduler. The master modport drives the write
//               port, commit and period tick. The slave modport (the
//               scheduler) drives the live parameters and status.
// Ports       : i_wr_en/i_wr_addr/i_wr_data  shadow write port
//               i_commit, i_period_tick     control pulses
//               o_var_*                     live FOG loop parameters
//               o_busy/o_done/o_err/o_late  status
//               o_apply_cnt                 apply counter
// Revision    : 1.0 - initial release
// ============================================================================
interface fog_param_scheduler_if;
  logic        i_wr_en;
  logic [3:0]  i_wr_addr;
  logic [31:0] i_wr_data;
  logic        i_commit;
  logic        i_period_tick;

  logic [31:0] o_var_freq_cnt;
  logic [31:0] o_var_amp_H;
  logic [31:0] o_var_amp_L;
  logic        o_var_polarity;
  logic [31:0] o_var_wait_cnt;
  logic [31:0] o_var_err_offset;
  logic [31:0] o_var_avg_sel;
  logic [31:0] o_var_gainSel_step;
  logic [31:0] o_var_gainSel_ramp;
  logic [31:0] o_var_fb_ON;
  logic [31:0] o_var_const_step;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic        o_late;
  logic [15:0] o_apply_cnt;

  modport master (
    output i_wr_en, i_wr_addr, i_wr_data, i_commit, i_period_tick,
    input  o_var_freq_cnt, o_var_amp_H, o_var_amp_L, o_var_polarity,
           o_var_wait_cnt, o_var_err_offset, o_var_avg_sel,
           o_var_gainSel_step, o_var_gainSel_ramp, o_var_fb_ON,
           o_var_const_step, o_busy, o_done, o_err, o_late, o_apply_cnt
  );

  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_data, i_commit, i_period_tick,
    output o_var_freq_cnt, o_var_amp_H, o_var_amp_L, o_var_polarity,
           o_var_wait_cnt, o_var_err_offset, o_var_avg_sel,
           o_var_gainSel_step, o_var_gainSel_ramp, o_var_fb_ON,
           o_var_const_step, o_busy, o_done, o_err, o_late, o_apply_cnt
  );
endinterface
`default_nettype wire

// File: rtl/fog_param_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fog_param_scheduler
// Description : Double-buffered FOG loop parameter scheduler. The CPU writes
//               a shadow bank; a commit validates it and arms a copy to the
//               live bank that happens on the next modulation-period tick
//               (or on a timeout, flagged as late).
// Ports       : CLOCK_CPU   sole clock
//               RST_SYNC_N  asynchronous active-low reset
//               bus         fog_param_scheduler_if.slave (write port, commit,
//                           period tick, live parameters, status)
// Revision    : 1.0 - initial release
// ============================================================================
module fog_param_scheduler #(
  parameter int TIMEOUT_CYC  = 1_000_000,
  parameter int MIN_FREQ_CNT = 4,
  parameter int MAX_AVG_SEL  = 15,
  parameter int MAX_GAIN_SEL = 31
) (
  input  logic                   CLOCK_CPU,
  input  logic                   RST_SYNC_N,
  fog_param_scheduler_if.slave   bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_ARMED = 2'd2;

  localparam int          NUM_PARAMS = 11;
  localparam logic [3:0]  LAST_ADDR  = 4'd10;
  localparam logic [31:0] MIN_FREQ   = 32'(MIN_FREQ_CNT);
  localparam logic [31:0] AVG_LIM    = 32'(MAX_AVG_SEL);
  localparam logic [31:0] GAIN_LIM   = 32'(MAX_GAIN_SEL);
  localparam logic [31:0] TMO_LAST   = 32'(TIMEOUT_CYC - 1);

  // Bank index map: 0 freq_cnt, 1 amp_H, 2 amp_L, 3 polarity, 4 wait_cnt,
  // 5 err_offset, 6 avg_sel, 7 gainSel_step, 8 gainSel_ramp, 9 fb_ON,
  // 10 const_step.
  function automatic logic [31:0] default_val(input int idx);
    logic [31:0] v;
    v = 32'd0;
    case (idx)
      0:       v = 32'd1000;
      1:       v = 32'd5000;
      2:       v = 32'd5000;
      4:       v = 32'd50;
      6:       v = 32'd10;
      7:       v = 32'd5;
      8:       v = 32'd10;
      9:       v = 32'd1;
      10:      v = 32'd100;
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  // Polarity keeps bit 0; selector fields saturate as unsigned values.
  function automatic logic [31:0] shape_write(input logic [3:0] addr,
                                              input logic [31:0] data);
    logic [31:0] v;
    v = data;
    case (addr)
      4'd3:       v = {31'd0, data[0]};
      4'd6:       v = (data > AVG_LIM)  ? AVG_LIM  : data;
      4'd7, 4'd8: v = (data > GAIN_LIM) ? GAIN_LIM : data;
      default:    v = data;
    endcase
    return v;
  endfunction

  logic [1:0]  state;
  logic [31:0] shadow [NUM_PARAMS];
  logic [31:0] live   [NUM_PARAMS];
  logic [31:0] tmo_cnt;
  logic        busy;
  logic        done;
  logic        err;
  logic        late;
  logic [15:0] apply_cnt;

  // A write arriving together with a commit is parked here so that the
  // commit validates and applies the pre-write bank; it is folded into the
  // shadow bank when the scheduler returns to IDLE.
  logic        pend_valid;
  logic [3:0]  pend_addr;
  logic [31:0] pend_data;

  logic wr_known;
  logic bank_valid;
  logic tmo_hit;
  logic apply_now;

  assign wr_known   = (bus.i_wr_addr <= LAST_ADDR);
  assign bank_valid = (shadow[0] >= MIN_FREQ) &&
                      (shadow[4] <  shadow[0]) &&
                      ($signed(shadow[2]) <= $signed(shadow[1]));
  assign tmo_hit    = (tmo_cnt == TMO_LAST);
  assign apply_now  = (state == ST_ARMED) && (bus.i_period_tick || tmo_hit);

  always_ff @(posedge CLOCK_CPU or negedge RST_SYNC_N) begin
    if (!RST_SYNC_N) begin
      state      <= ST_IDLE;
      tmo_cnt    <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      late       <= 1'b0;
      apply_cnt  <= 16'd0;
      pend_valid <= 1'b0;
      pend_addr  <= 4'd0;
      pend_data  <= 32'd0;
      for (int k = 0; k < NUM_PARAMS; k++) begin
        shadow[k] <= default_val(k);
        live[k]   <= default_val(k);
      end
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.i_wr_en) begin
            if (!wr_known) begin
              err <= 1'b1;
            end else if (bus.i_commit) begin
              pend_valid <= 1'b1;
              pend_addr  <= bus.i_wr_addr;
              pend_data  <= shape_write(bus.i_wr_addr, bus.i_wr_data);
            end else begin
              shadow[bus.i_wr_addr] <= shape_write(bus.i_wr_addr, bus.i_wr_data);
            end
          end
          if (bus.i_commit) begin
            state <= ST_CHECK;
            busy  <= 1'b1;
          end
        end

        ST_CHECK: begin
          if (bank_valid) begin
            state   <= ST_ARMED;
            err     <= 1'b0;
            late    <= 1'b0;
            tmo_cnt <= 32'd0;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            err   <= 1'b1;
            if (pend_valid) begin
              shadow[pend_addr] <= pend_data;
              pend_valid        <= 1'b0;
            end
          end
          // A dropped write is reported even if this commit is accepted.
          if (bus.i_wr_en) begin
            err <= 1'b1;
          end
        end

        ST_ARMED: begin
          if (apply_now) begin
            for (int k = 0; k < NUM_PARAMS; k++) begin
              live[k] <= shadow[k];
            end
            apply_cnt <= apply_cnt + 16'd1;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
            // A tick coinciding with the timeout counts as on time.
            if (!bus.i_period_tick) begin
              late <= 1'b1;
            end
            if (pend_valid) begin
              shadow[pend_addr] <= pend_data;
              pend_valid        <= 1'b0;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
          if (bus.i_wr_en) begin
            err <= 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_var_freq_cnt     = live[0];
  assign bus.o_var_amp_H        = live[1];
  assign bus.o_var_amp_L        = live[2];
  // Only bit 0 of the polarity entry can ever be set, so the OR is bit 0.
  assign bus.o_var_polarity     = |live[3];
  assign bus.o_var_wait_cnt     = live[4];
  assign bus.o_var_err_offset   = live[5];
  assign bus.o_var_avg_sel      = live[6];
  assign bus.o_var_gainSel_step = live[7];
  assign bus.o_var_gainSel_ramp = live[8];
  assign bus.o_var_fb_ON        = live[9];
  assign bus.o_var_const_step   = live[10];
  assign bus.o_busy             = busy;
  assign bus.o_done             = done;
  assign bus.o_err              = err;
  assign bus.o_late             = late;
  assign bus.o_apply_cnt        = apply_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fog_param_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_fog_param_scheduler
// Description : Self-checking bench for fog_param_scheduler: a table of
//               shadow-bank configurations with expected validation/clamp
//               results, plus directed sequences for timeout, busy writes,
//               same-cycle write+commit, reset while armed and counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fog_param_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fog_param_scheduler_if bus ();

  fog_param_scheduler #(
    .TIMEOUT_CYC (16),
    .MIN_FREQ_CNT(4),
    .MAX_AVG_SEL (15),
    .MAX_GAIN_SEL(31)
  ) dut (
    .CLOCK_CPU (clk),
    .RST_SYNC_N(rst_n),
    .bus       (bus)
  );

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;
  logic [31:0] m_live [11];

  typedef struct {
    logic [31:0] freq, wait_c, amp_h, amp_l, avg, gstep, gramp, pol;
    bit          ok;
    logic [31:0] e_avg, e_gstep, e_gramp, e_pol;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] out_val(input int k);
    logic [31:0] v;
    v = 32'd0;
    case (k)
      0:  v = bus.o_var_freq_cnt;
      1:  v = bus.o_var_amp_H;
      2:  v = bus.o_var_amp_L;
      3:  v = {31'd0, bus.o_var_polarity};
      4:  v = bus.o_var_wait_cnt;
      5:  v = bus.o_var_err_offset;
      6:  v = bus.o_var_avg_sel;
      7:  v = bus.o_var_gainSel_step;
      8:  v = bus.o_var_gainSel_ramp;
      9:  v = bus.o_var_fb_ON;
      10: v = bus.o_var_const_step;
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  task automatic check_live(input string tag);
    for (int k = 0; k < 11; k++) begin
      chk($sformatf("%s live[%0d]", tag, k), out_val(k), m_live[k]);
    end
  endtask

  task automatic set_defaults();
    m_live[0] = 1000; m_live[1] = 5000; m_live[2] = 5000; m_live[3] = 0;
    m_live[4] = 50;   m_live[5] = 0;    m_live[6] = 10;   m_live[7] = 5;
    m_live[8] = 10;   m_live[9] = 1;    m_live[10] = 100;
  endtask

  // All tasks start and end at a falling edge.
  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    bus.i_wr_en = 1'b1; bus.i_wr_addr = a; bus.i_wr_data = d;
    @(negedge clk);
    bus.i_wr_en = 1'b0;
  endtask

  task automatic pulse_commit();
    bus.i_commit = 1'b1;
    @(negedge clk);
    bus.i_commit = 1'b0;
  endtask

  task automatic pulse_tick();
    bus.i_period_tick = 1'b1;
    @(negedge clk);
    bus.i_period_tick = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            freq   wait   amp_h         amp_l         avg           gstep  gramp  pol ok  e_avg e_gs e_gr e_pol
    vecs[0] = '{32'd2000, 32'd100, 32'd5000, 32'd5000, 32'd40, 32'd5, 32'd10, 32'd0, 1'b1, 32'd15, 32'd5, 32'd10, 32'd0};
    vecs[1] = '{32'd2000, 32'd3000, 32'd5000, 32'd5000, 32'd10, 32'd5, 32'd10, 32'd0, 1'b0, 0, 0, 0, 0};
    vecs[2] = '{32'd3, 32'd1, 32'd5000, 32'd5000, 32'd10, 32'd5, 32'd10, 32'd0, 1'b0, 0, 0, 0, 0};
    vecs[3] = '{32'd4, 32'd3, 32'hFFFF_FFFB, 32'hFFFF_FFF6, 32'hFFFF_FFFF, 32'd32, 32'd100, 32'd3, 1'b1, 32'd15, 32'd31, 32'd31, 32'd1};
    vecs[4] = '{32'd4, 32'd4, 32'd5000, 32'd5000, 32'd10, 32'd5, 32'd10, 32'd0, 1'b0, 0, 0, 0, 0};
    vecs[5] = '{32'd100, 32'd10, 32'hFFFF_FFFF, 32'd5, 32'd10, 32'd5, 32'd10, 32'd0, 1'b0, 0, 0, 0, 0};
    vecs[6] = '{32'd100, 32'd10, 32'd5, 32'hFFFF_FFFF, 32'd15, 32'd31, 32'd31, 32'd2, 1'b1, 32'd15, 32'd31, 32'd31, 32'd0};

    bus.i_wr_en = 0; bus.i_wr_addr = 0; bus.i_wr_data = 0;
    bus.i_commit = 0; bus.i_period_tick = 0;
    set_defaults();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Reset defaults
    check_live("reset");
    chk("reset busy", {31'd0, bus.o_busy}, 0);
    chk("reset err",  {31'd0, bus.o_err},  0);
    chk("reset late", {31'd0, bus.o_late}, 0);
    chk("reset done", {31'd0, bus.o_done}, 0);
    chk("reset cnt",  {16'd0, bus.o_apply_cnt}, 0);

    // Table of configurations
    for (int v = 0; v < 7; v++) begin
      do_write(4'd0, vecs[v].freq);
      do_write(4'd4, vecs[v].wait_c);
      do_write(4'd1, vecs[v].amp_h);
      do_write(4'd2, vecs[v].amp_l);
      do_write(4'd6, vecs[v].avg);
      do_write(4'd7, vecs[v].gstep);
      do_write(4'd8, vecs[v].gramp);
      do_write(4'd3, vecs[v].pol);
      pulse_commit();
      chk($sformatf("v%0d busy in check", v), {31'd0, bus.o_busy}, 1);
      @(negedge clk);
      if (vecs[v].ok) begin
        chk($sformatf("v%0d busy armed", v), {31'd0, bus.o_busy}, 1);
        chk($sformatf("v%0d err cleared", v), {31'd0, bus.o_err}, 0);
      end else begin
        chk($sformatf("v%0d err set", v), {31'd0, bus.o_err}, 1);
        chk($sformatf("v%0d busy idle", v), {31'd0, bus.o_busy}, 0);
      end
      repeat (3) @(negedge clk);
      check_live($sformatf("v%0d pre-tick", v));
      pulse_tick();
      if (vecs[v].ok) begin
        m_live[0] = vecs[v].freq;  m_live[4] = vecs[v].wait_c;
        m_live[1] = vecs[v].amp_h; m_live[2] = vecs[v].amp_l;
        m_live[6] = vecs[v].e_avg; m_live[7] = vecs[v].e_gstep;
        m_live[8] = vecs[v].e_gramp; m_live[3] = vecs[v].e_pol;
        exp_cnt++;
      end
      chk($sformatf("v%0d done", v), {31'd0, bus.o_done}, {31'd0, vecs[v].ok});
      chk($sformatf("v%0d busy after", v), {31'd0, bus.o_busy}, 0);
      chk($sformatf("v%0d late", v), {31'd0, bus.o_late}, 0);
      chk($sformatf("v%0d cnt", v), {16'd0, bus.o_apply_cnt}, exp_cnt);
      check_live($sformatf("v%0d post-tick", v));
      @(negedge clk);
      chk($sformatf("v%0d done low", v), {31'd0, bus.o_done}, 0);
    end

    // Timeout-forced apply: ARMED from the second edge, apply 16 edges later
    do_write(4'd5, 32'd7);
    pulse_commit();
    repeat (16) @(negedge clk);
    chk("tmo busy before", {31'd0, bus.o_busy}, 1);
    chk("tmo live before", bus.o_var_err_offset, m_live[5]);
    @(negedge clk);
    m_live[5] = 7; exp_cnt++;
    chk("tmo live after", bus.o_var_err_offset, 32'd7);
    chk("tmo late", {31'd0, bus.o_late}, 1);
    chk("tmo done", {31'd0, bus.o_done}, 1);
    chk("tmo cnt", {16'd0, bus.o_apply_cnt}, exp_cnt);

    // Tick coinciding with the timeout cycle is an on-time apply
    do_write(4'd5, 32'd9);
    pulse_commit();
    @(negedge clk);
    chk("coinc late cleared", {31'd0, bus.o_late}, 0);
    repeat (15) @(negedge clk);
    chk("coinc live before", bus.o_var_err_offset, 32'd7);
    pulse_tick();
    m_live[5] = 9; exp_cnt++;
    chk("coinc live after", bus.o_var_err_offset, 32'd9);
    chk("coinc late", {31'd0, bus.o_late}, 0);
    chk("coinc cnt", {16'd0, bus.o_apply_cnt}, exp_cnt);

    // Tick during CHECK is missed
    do_write(4'd9, 32'd0);
    pulse_commit();
    pulse_tick();
    chk("chk-tick busy", {31'd0, bus.o_busy}, 1);
    chk("chk-tick live", bus.o_var_fb_ON, 32'd1);
    repeat (2) @(negedge clk);
    pulse_tick();
    m_live[9] = 0; exp_cnt++;
    chk("chk-tick apply", bus.o_var_fb_ON, 32'd0);
    chk("chk-tick cnt", {16'd0, bus.o_apply_cnt}, exp_cnt);

    // Write while ARMED is dropped and flagged
    do_write(4'd10, 32'd55);
    pulse_commit();
    @(negedge clk);
    do_write(4'd10, 32'd99);
    chk("busy-wr err", {31'd0, bus.o_err}, 1);
    pulse_tick();
    m_live[10] = 55; exp_cnt++;
    chk("busy-wr live", bus.o_var_const_step, 32'd55);
    chk("busy-wr err sticky", {31'd0, bus.o_err}, 1);

    // Accepted commit clears err; reserved index sets it
    pulse_commit();
    @(negedge clk);
    chk("clr err", {31'd0, bus.o_err}, 0);
    pulse_tick();
    exp_cnt++;
    do_write(4'd12, 32'd5);
    chk("reserved err", {31'd0, bus.o_err}, 1);
    check_live("reserved live");

    // Same-cycle write and commit: validates and applies pre-write bank
    bus.i_wr_en = 1'b1; bus.i_wr_addr = 4'd4; bus.i_wr_data = 32'd5000;
    bus.i_commit = 1'b1;
    @(negedge clk);
    bus.i_wr_en = 1'b0; bus.i_commit = 1'b0;
    @(negedge clk);
    chk("samecyc accepted", {31'd0, bus.o_err}, 0);
    chk("samecyc busy", {31'd0, bus.o_busy}, 1);
    pulse_tick();
    exp_cnt++;
    chk("samecyc wait old", bus.o_var_wait_cnt, m_live[4]);
    chk("samecyc cnt", {16'd0, bus.o_apply_cnt}, exp_cnt);
    pulse_commit();
    @(negedge clk);
    chk("samecyc next rejects", {31'd0, bus.o_err}, 1);

    // Reset while ARMED
    do_write(4'd4, 32'd20);
    do_write(4'd10, 32'd77);
    pulse_commit();
    @(negedge clk);
    chk("rst pre busy", {31'd0, bus.o_busy}, 1);
    rst_n = 1'b0;
    #1;
    set_defaults();
    exp_cnt = 0;
    check_live("rst async");
    chk("rst busy", {31'd0, bus.o_busy}, 0);
    chk("rst err", {31'd0, bus.o_err}, 0);
    chk("rst cnt", {16'd0, bus.o_apply_cnt}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_tick();
    chk("rst no apply cnt", {16'd0, bus.o_apply_cnt}, 0);
    chk("rst no apply done", {31'd0, bus.o_done}, 0);
    pulse_commit();
    @(negedge clk);
    pulse_tick();
    exp_cnt++;
    check_live("rst reapply");
    chk("rst reapply cnt", {16'd0, bus.o_apply_cnt}, exp_cnt);

    // Apply counter wrap
    force dut.apply_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.apply_cnt;
    @(negedge clk);
    chk("wrap preload", {16'd0, bus.o_apply_cnt}, 32'h0000_FFFF);
    pulse_commit();
    @(negedge clk);
    pulse_tick();
    chk("wrap cnt", {16'd0, bus.o_apply_cnt}, 0);
    chk("wrap done", {31'd0, bus.o_done}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
